// File: rtl/io_keys_pkg.sv
// io_keys_pkg: register offsets, decode bits and debounce state type for the io_keys push-button peripheral.
package io_keys_pkg;
    localparam logic [31:0] KEYS_STATE_OFF = 32'h110;
    localparam logic [31:0] KEYS_EDGE_OFF = 32'h114;
    localparam int IO_KEYS_bit = 4;
    localparam int IO_KEYS_EDGE_bit = 2;
    typedef enum logic {STABLE, COUNTING} deb_state_t;
endpackage

// File: rtl/io_keys_key_debounce.sv
// key_debounce: two-flop synchroniser plus STABLE/COUNTING debounce FSM for one active-low key.
// The level output changes DEBOUNCE_CYCLES cycles after the synchronised input starts to differ.
module key_debounce
    import io_keys_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic r_sync1, r_sync2, r_level;
    logic [CNT_W-1:0] r_cnt;
    deb_state_t r_state, w_state_nxt;
    logic w_diff, w_done;
    always_ff @(posedge clk) begin
        if (reset) r_state <= STABLE;
        else r_state <= w_state_nxt;
    end
    // In STABLE the counter is 0, so a single-cycle debounce completes on the first differing cycle.
    always_comb begin
        w_diff = r_sync2 != r_level;
        w_done = w_diff && (r_state == STABLE ? LAST == '0 : r_cnt == LAST);
        w_state_nxt = (w_diff && !w_done) ? COUNTING : STABLE;
    end
    always_comb begin
        o_level = r_level;
        o_rise = w_done & r_sync2;
        o_fall = w_done & ~r_sync2;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_sync1 <= ~i_key_n;
            r_sync2 <= r_sync1;
            r_level <= w_done ? r_sync2 : r_level;
            r_cnt <= (w_state_nxt == COUNTING) ? r_cnt + CNT_W'(1) : '0;
        end
    end
endmodule

// File: rtl/io_keys.sv
// io_keys: memory-mapped debounced push-button peripheral (KEY_STATE at 0x110, sticky W1C KEY_EDGE at 0x114).
// Define IO_KEYS_RELEASE_EDGE_EN to also capture release events in KEY_EDGE[2*NKEYS-1:NKEYS].
module io_keys
    import io_keys_pkg::*;
#(
    parameter int NKEYS = 4,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_n,
    input  logic             sel,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             hit
);
`ifdef IO_KEYS_RELEASE_EDGE_EN
    localparam int EW = 2 * NKEYS;
`else
    localparam int EW = NKEYS;
`endif
    logic [NKEYS-1:0] w_level, w_rise, w_fall;
    logic [EW-1:0] r_edge, w_set, w_clr;
    for (genvar g = 0; g < NKEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_deb (
            .clk(clk),
            .reset(reset),
            .i_key_n(key_n[g]),
            .o_level(w_level[g]),
            .o_rise(w_rise[g]),
            .o_fall(w_fall[g])
        );
    end
`ifdef IO_KEYS_RELEASE_EDGE_EN
    assign w_set = {w_fall, w_rise};
    logic w_unused;
    assign w_unused = &{1'b0, addr[31:5], addr[3], addr[1:0], wdata[31:EW]};
`else
    assign w_set = w_rise;
    logic w_unused;
    assign w_unused = &{1'b0, addr[31:5], addr[3], addr[1:0], wdata[31:EW], w_fall};
`endif
    always_comb begin
        hit = sel & addr[IO_KEYS_bit];
        w_clr = {EW{we & hit & addr[IO_KEYS_EDGE_bit]}} & wdata[EW-1:0];
        rdata = !hit ? 32'd0 : addr[IO_KEYS_EDGE_bit] ? 32'(r_edge) : 32'(w_level);
    end
    // A new event in the same cycle as its clearing write keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) r_edge <= '0;
        else r_edge <= w_set | (r_edge & ~w_clr);
    end
endmodule

// File: tb/tb_io_keys.sv
// tb_io_keys: scoreboard-driven bench for io_keys; release-edge expectations follow IO_KEYS_RELEASE_EDGE_EN.
module tb_io_keys;
    import io_keys_pkg::*;
`ifdef IO_KEYS_RELEASE_EDGE_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif
    logic clk, reset, sel, we, hit;
    logic [3:0] key_n;
    logic [31:0] addr, wdata, rdata;
    logic [31:0] exp_q[$];
    logic [31:0] got, expv, m_edge;
    int n_checks = 0;
    int n_fail = 0;

    io_keys dut (
        .clk(clk), .reset(reset), .key_n(key_n), .sel(sel), .addr(addr),
        .we(we), .wdata(wdata), .rdata(rdata), .hit(hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        sel = 1'b1;
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        sel = 1'b1;
        addr = a;
        wdata = d;
        we = 1'b1;
        tick();
        we = 1'b0;
        wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        key_n = 4'hF;
        sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick(); tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd(KEYS_STATE_OFF, got);
        n_checks++;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_hit: got %b expected 1", hit); end
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL reset_state: got %h expected %h", got, expv); end
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL reset_edge: got %h expected %h", got, expv); end
        sel = 1'b0;
        #1;
        n_checks++;
        if (hit !== 1'b0 || rdata !== 32'h0) begin n_fail++; $display("FAIL nosel_read: got hit=%b rdata=%h expected hit=0 rdata=0", hit, rdata); end
        reset = 1'b0;
        tick();
        exp_q.push_back(32'h0);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL post_reset_edge: got %h expected %h", got, expv); end
        m_edge = '0;
    endtask

    task automatic test_press();
        key_n = 4'b1101;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(i == 5 ? 32'h2 : 32'h0);
            tick();
            rd(KEYS_STATE_OFF, got);
            n_checks++; expv = exp_q.pop_front();
            if (got !== expv) begin n_fail++; $display("FAIL press_state_c%0d: got %h expected %h", i, got, expv); end
        end
        m_edge = 32'h2;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL press_edge: got %h expected %h", got, expv); end
        key_n = 4'hF;
        repeat (6) tick();
        m_edge |= REL ? 32'h20 : 32'h0;
        exp_q.push_back(32'h0); exp_q.push_back(m_edge);
        rd(KEYS_STATE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL release_state: got %h expected %h", got, expv); end
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL press_edge_sticky: got %h expected %h", got, expv); end
    endtask

    task automatic test_glitch();
        wr(KEYS_EDGE_OFF, 32'hFF);
        m_edge = '0;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL clear_all: got %h expected %h", got, expv); end
        key_n = 4'b1011;
        tick(); tick();
        key_n = 4'hF;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'h0); exp_q.push_back(32'h0);
            tick();
            rd(KEYS_STATE_OFF, got);
            n_checks++; expv = exp_q.pop_front();
            if (got !== expv) begin n_fail++; $display("FAIL glitch_state_c%0d: got %h expected %h", i, got, expv); end
            rd(KEYS_EDGE_OFF, got);
            n_checks++; expv = exp_q.pop_front();
            if (got !== expv) begin n_fail++; $display("FAIL glitch_edge_c%0d: got %h expected %h", i, got, expv); end
        end
    endtask

    task automatic test_w1c();
        key_n = 4'b1001;
        repeat (6) tick();
        m_edge = 32'h6;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL w1c_pre: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'h2);
        m_edge = 32'h4;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL w1c_clear1: got %h expected %h", got, expv); end
        wr(KEYS_STATE_OFF, 32'hF);
        wr(KEYS_EDGE_OFF, 32'h0);
        exp_q.push_back(32'h6); exp_q.push_back(m_edge);
        rd(KEYS_STATE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL state_ro: got %h expected %h", got, expv); end
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL w1c_zero_write: got %h expected %h", got, expv); end
        key_n = 4'hF;
        repeat (6) tick();
        m_edge |= REL ? 32'h60 : 32'h0;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL w1c_release: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'hFFFF_FFFF);
        m_edge = '0;
    endtask

    task automatic test_collision();
        key_n = 4'b1101;
        repeat (4) tick();
        exp_q.push_back(32'h0);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL coll_pre: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'h2);
        m_edge = 32'h2;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL coll_set_wins: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'h2);
        m_edge = 32'h0;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL coll_later_clear: got %h expected %h", got, expv); end
        key_n = 4'hF;
        repeat (6) tick();
        wr(KEYS_EDGE_OFF, 32'hFF);
    endtask

    task automatic test_reset_mid();
        key_n = 4'b0111;
        repeat (4) tick();
        reset = 1'b1;
        tick(); tick();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        rd(KEYS_STATE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL midrst_state: got %h expected %h", got, expv); end
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL midrst_edge: got %h expected %h", got, expv); end
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(i == 5 ? 32'h8 : 32'h0);
            tick();
            rd(KEYS_STATE_OFF, got);
            n_checks++; expv = exp_q.pop_front();
            if (got !== expv) begin n_fail++; $display("FAIL held_state_c%0d: got %h expected %h", i, got, expv); end
        end
        m_edge = 32'h8;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL held_edge: got %h expected %h", got, expv); end
        key_n = 4'hF;
        repeat (6) tick();
        wr(KEYS_EDGE_OFF, 32'hFF);
        m_edge = '0;
    endtask

    task automatic test_release();
        key_n = 4'b1110;
        repeat (6) tick();
        exp_q.push_back(32'h1);
        rd(KEYS_STATE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL rel_press_state: got %h expected %h", got, expv); end
        key_n = 4'hF;
        repeat (6) tick();
        m_edge = REL ? 32'h11 : 32'h01;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL rel_edge: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'h10);
        m_edge = 32'h01;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL rel_clear_hi: got %h expected %h", got, expv); end
        wr(KEYS_EDGE_OFF, 32'h01);
        m_edge = 32'h0;
        exp_q.push_back(m_edge);
        rd(KEYS_EDGE_OFF, got);
        n_checks++; expv = exp_q.pop_front();
        if (got !== expv) begin n_fail++; $display("FAIL rel_clear_lo: got %h expected %h", got, expv); end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_w1c();
        test_collision();
        test_reset_mid();
        test_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
